fetch_pc_ctrl: RTL and testbench

//  Owns the PC and sequences instruction fetch over a req/ack imem port.

---
 rtl/fetch_pc_ctrl_pkg.sv | 22 ++
 rtl/fetch_pc_ctrl_if.sv | 17 +
 rtl/fetch_pc_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg
//  Shared types and constants for the instruction-fetch PC controller.
//  ADDR_W / INST_W : fetch address and instruction widths.
//  RESET_PC_DEF    : default boot vector.
//  state_e         : fetch sequencer states.
package fetch_pc_ctrl_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Sequential next-PC, wraps at 32 bits.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if
//  Instruction-memory request/ack port.
//  imem_req   : fetch request (held until ack)
//  imem_addr  : fetch address (stable until ack)
//  imem_ack   : fetch complete, imem_rdata valid this cycle
//  imem_rdata : fetched instruction
//  master = fetch unit side, slave = memory side.
interface fetch_pc_ctrl_if;
  import fetch_pc_ctrl_pkg::*;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
//  Owns the PC and sequences instruction fetch over the imem req/ack port.
//  Applies ID branch redirects after the delay slot, exception/eret flushes
//  (flush beats everything), and honours IF/ID stalls.
//  Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall_if                 : IF/ID must hold
//   flush, flush_pc          : exception/eret redirect
//   branch_flag, branch_addr : taken branch from ID
//   imem                     : fetch port (master)
//   if_valid, if_pc, if_inst : instruction presented to IF/ID
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  fetch_pc_ctrl_if.master   imem,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;          // next address to fetch
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;  // address of current fetch
  logic              redir_v_q, redir_v_d;
  logic [ADDR_W-1:0] redir_addr_q, redir_addr_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] next_pc;
  logic              br_take;

  assign imem.imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem.imem_addr = req_addr_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    redir_v_d    = redir_v_q;
    redir_addr_d = redir_addr_q;
    buf_d        = buf_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    next_pc      = redir_v_q ? redir_addr_q : pc_inc(req_addr_q);
    br_take      = branch_flag & ~stall_if;

    if (state_q == ST_BOOT) begin
      req_addr_d = pc_q;
      state_d    = ST_REQ;
    end else if (flush) begin
      pc_d       = flush_pc;
      redir_v_d  = 1'b0;
      if_valid_d = 1'b0;
      buf_d      = '0;
      // An outstanding fetch cannot be aborted; let it land in DRAIN.
      if ((state_q == ST_REQ && !imem.imem_ack) || state_q == ST_DRAIN) begin
        state_d = ST_DRAIN;
      end else begin
        req_addr_d = flush_pc;
        state_d    = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem.imem_ack) begin
            redir_v_d = 1'b0;
            if (!stall_if) begin
              if_valid_d = 1'b1;
              if_pc_d    = req_addr_q;
              if_inst_d  = imem.imem_rdata;
              // The ack just delivered the delay slot, go straight to target.
              pc_d       = br_take ? branch_addr : next_pc;
              req_addr_d = br_take ? branch_addr : next_pc;
            end else begin
              buf_d   = imem.imem_rdata;
              pc_d    = next_pc;
              state_d = ST_HOLD;
            end
          end else if (!stall_if) begin
            if_valid_d = 1'b0;
            // Delay slot still in flight: remember target for its ack.
            if (branch_flag) begin
              redir_v_d    = 1'b1;
              redir_addr_d = branch_addr;
            end
          end
        end
        ST_HOLD: begin
          // req_addr still names the buffered instruction.
          if (!stall_if) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_addr_q;
            if_inst_d  = buf_q;
            pc_d       = branch_flag ? branch_addr : pc_q;
            req_addr_d = branch_flag ? branch_addr : pc_q;
            state_d    = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem.imem_ack) begin
            req_addr_d = pc_q;
            state_d    = ST_REQ;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      redir_v_q    <= 1'b0;
      redir_addr_q <= '0;
      buf_q        <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_inst_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      redir_v_q    <= redir_v_d;
      redir_addr_q <= redir_addr_d;
      buf_q        <= buf_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl
//  Directed table of per-cycle vectors for fetch_pc_ctrl plus a hand-written
//  reset-during-DRAIN sequence. Memory returns inst = addr ^ 5A5A0F0F.
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, flush, branch_flag;
  logic [31:0] flush_pc, branch_addr;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  int          errors = 0;
  int          checks = 0;

  fetch_pc_ctrl_if bus();

  fetch_pc_ctrl dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_addr(branch_addr), .imem(bus.master),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mi(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_rdata = mi(bus.imem_addr);

  typedef struct {
    logic        stall, fl;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic stall, input logic fl, input logic [31:0] fpc,
                             input logic br, input logic [31:0] baddr, input logic ack,
                             input logic e_req, input logic [31:0] e_addr, input logic e_v,
                             input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t r;
    r.stall = stall; r.fl = fl; r.fpc = fpc; r.br = br; r.baddr = baddr; r.ack = ack;
    r.e_req = e_req; r.e_addr = e_addr; r.e_v = e_v; r.e_pc = e_pc; r.e_inst = e_inst;
    return r;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic idle_in();
    stall_if = 0; flush = 0; flush_pc = 0; branch_flag = 0; branch_addr = 0;
    bus.imem_ack = 0;
  endtask

  initial begin
    // stall fl fpc br baddr ack | req addr | v pc inst
    tbl.push_back(v(0,0,0,0,0,0, 0,32'h0,        0,32'h0,        32'h0));            // 1 BOOT
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hBFC00000, 1,32'hBFC00000, mi(32'hBFC00000)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hBFC00004, 1,32'hBFC00004, mi(32'hBFC00004)));
    tbl.push_back(v(0,1,32'hF8,0,0,1, 1,32'hBFC00008, 0,32'hBFC00004, mi(32'hBFC00004)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hF8,  1,32'hF8,  mi(32'hF8)));                  // 5
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hFC,  1,32'hFC,  mi(32'hFC)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h100, 1,32'h100, mi(32'h100)));
    tbl.push_back(v(0,0,0,1,32'h200,1, 1,32'h104, 1,32'h104, mi(32'h104)));          // branch, slot acked
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h200, 1,32'h200, mi(32'h200)));
    tbl.push_back(v(0,1,32'hFC,0,0,1, 1,32'h204, 0,32'h200, mi(32'h200)));           // 10
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hFC,  1,32'hFC,  mi(32'hFC)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h100, 1,32'h100, mi(32'h100)));
    tbl.push_back(v(0,0,0,1,32'h200,0, 1,32'h104, 0,32'h100, mi(32'h100)));          // redir pending
    tbl.push_back(v(0,0,0,0,0,0, 1,32'h104, 0,32'h100, mi(32'h100)));
    tbl.push_back(v(0,0,0,0,0,0, 1,32'h104, 0,32'h100, mi(32'h100)));                // 15
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h104, 1,32'h104, mi(32'h104)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h200, 1,32'h200, mi(32'h200)));                // no 0x108
    tbl.push_back(v(1,0,0,0,0,1, 1,32'h204, 1,32'h200, mi(32'h200)));                // ack under stall
    tbl.push_back(v(1,0,0,0,0,0, 0,32'h0,   1,32'h200, mi(32'h200)));                // HOLD
    tbl.push_back(v(1,0,0,0,0,0, 0,32'h0,   1,32'h200, mi(32'h200)));                // 20
    tbl.push_back(v(0,0,0,0,0,0, 0,32'h0,   1,32'h204, mi(32'h204)));                // release
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h208, 1,32'h208, mi(32'h208)));
    tbl.push_back(v(0,1,32'hBFC00380,0,0,0, 1,32'h20C, 0,32'h208, mi(32'h208)));     // -> DRAIN
    tbl.push_back(v(0,0,0,0,0,0, 1,32'h20C, 0,32'h208, mi(32'h208)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h20C, 0,32'h208, mi(32'h208)));                // 25 stale ack
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hBFC00380, 1,32'hBFC00380, mi(32'hBFC00380)));
    tbl.push_back(v(0,1,32'hBFC00180,1,32'h300,1, 1,32'hBFC00384, 0,32'hBFC00380, mi(32'hBFC00380)));
    tbl.push_back(v(0,0,0,0,0,0, 1,32'hBFC00180, 0,32'hBFC00380, mi(32'hBFC00380)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hBFC00180, 1,32'hBFC00180, mi(32'hBFC00180)));
    tbl.push_back(v(1,0,0,0,0,0, 1,32'hBFC00184, 1,32'hBFC00180, mi(32'hBFC00180))); // 30 stall, no bubble
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hBFC00184, 1,32'hBFC00184, mi(32'hBFC00184)));
    tbl.push_back(v(0,1,32'hFFFFFFFC,0,0,1, 1,32'hBFC00188, 0,32'hBFC00184, mi(32'hBFC00184)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'hFFFFFFFC, 1,32'hFFFFFFFC, mi(32'hFFFFFFFC)));
    tbl.push_back(v(0,0,0,0,0,1, 1,32'h0, 1,32'h0, mi(32'h0)));                      // wrap
    tbl.push_back(v(0,1,32'h40,0,0,0, 1,32'h4, 0,32'h0, mi(32'h0)));                 // 35 -> DRAIN

    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   0, 32'(bus.imem_req), 32'h0);
    chk("rst_addr",  0, bus.imem_addr, 32'h0);
    chk("rst_valid", 0, 32'(if_valid), 32'h0);
    chk("rst_pc",    0, if_pc, 32'h0);
    chk("rst_inst",  0, if_inst, 32'h0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall_if = tbl[i].stall; flush = tbl[i].fl; flush_pc = tbl[i].fpc;
      branch_flag = tbl[i].br; branch_addr = tbl[i].baddr; bus.imem_ack = tbl[i].ack;
      #1;
      chk("imem_req", i + 1, 32'(bus.imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk("imem_addr", i + 1, bus.imem_addr, tbl[i].e_addr);
      @(posedge clk);
      #1;
      chk("if_valid", i + 1, 32'(if_valid), 32'(tbl[i].e_v));
      chk("if_pc",    i + 1, if_pc, tbl[i].e_pc);
      chk("if_inst",  i + 1, if_inst, tbl[i].e_inst);
    end

    // Reset while DRAIN is waiting on an ack: ack ignored, everything zeroed.
    @(negedge clk);
    idle_in();
    rst = 1;
    bus.imem_ack = 1;
    #1;
    chk("drain_req", 100, 32'(bus.imem_req), 32'h1);
    @(posedge clk);
    #1;
    chk("drst_req",   101, 32'(bus.imem_req), 32'h0);
    chk("drst_addr",  101, bus.imem_addr, 32'h0);
    chk("drst_valid", 101, 32'(if_valid), 32'h0);
    chk("drst_pc",    101, if_pc, 32'h0);
    chk("drst_inst",  101, if_inst, 32'h0);
    @(negedge clk);
    rst = 0;
    bus.imem_ack = 1;
    #1;
    chk("boot_req", 102, 32'(bus.imem_req), 32'h0);
    @(negedge clk);
    chk("reboot_req",  103, 32'(bus.imem_req), 32'h1);
    chk("reboot_addr", 103, bus.imem_addr, 32'hBFC00000);
    @(posedge clk);
    #1;
    chk("reboot_valid", 103, 32'(if_valid), 32'h1);
    chk("reboot_pc",    103, if_pc, 32'hBFC00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
